// File: rtl/turn_scheduler_if.sv
// Request/acknowledge bus between the turn scheduler and the shared damage calculator.
interface turn_scheduler_if #(
    parameter int HP_W = 8
);
    logic            calc_req;
    logic            calc_is_player;
    logic            calc_ack;
    logic [HP_W-1:0] calc_damage;

    modport master (
        output calc_req,
        output calc_is_player,
        input  calc_ack,
        input  calc_damage
    );

    modport slave (
        input  calc_req,
        input  calc_is_player,
        output calc_ack,
        output calc_damage
    );
endinterface

// File: rtl/turn_scheduler.sv
// Sequences one battle turn: speed ordering, shared damage-calc handshake,
// saturating HP updates and ENTER-gated attack text.
module turn_scheduler #(
    parameter int HP_W             = 8,
    parameter bit TIE_PLAYER_FIRST = 1'b1,
    parameter int CALC_TIMEOUT     = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    turn_scheduler_if.master    calc,
    input  logic                turn_start,
    input  logic [HP_W-1:0]     player_speed,
    input  logic [HP_W-1:0]     enemy_speed,
    input  logic [HP_W-1:0]     player_hp_in,
    input  logic [HP_W-1:0]     enemy_hp_in,
    input  logic                text_ack,
    output logic                show_attack,
    output logic                show_is_player,
    output logic [HP_W-1:0]     player_hp,
    output logic [HP_W-1:0]     enemy_hp,
    output logic                turn_done,
    output logic                player_fainted,
    output logic                enemy_fainted,
    output logic                calc_err,
    output logic                busy
);
    localparam int TW = $clog2(CALC_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CALC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ORDER, S_REQ1, S_SHOW1, S_CHECK, S_REQ2, S_SHOW2, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            first_q, first_d;
    logic [HP_W-1:0] pspd_q, espd_q;
    logic [HP_W-1:0] php_q, ehp_q;
    logic [TW-1:0]   tmo_q;
    logic            calc_req_q, calc_is_player_q;
    logic            pfaint_q, efaint_q, err_q;
    logic            atk_player, def_dead, hit_ack, hit_tmo;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg);
        return (dmg >= hp) ? '0 : hp - dmg;
    endfunction

    // Attack 2 is always made by the side that did not go first.
    assign atk_player = (state_q == S_REQ2 || state_q == S_SHOW2) ? ~first_q : first_q;
    assign def_dead   = first_q ? (ehp_q == '0) : (php_q == '0);
    assign first_d    = (state_q == S_ORDER)
                        ? ((pspd_q > espd_q) || ((pspd_q == espd_q) && TIE_PLAYER_FIRST))
                        : first_q;

    always_comb begin
        state_d = state_q;
        hit_ack = 1'b0;
        hit_tmo = 1'b0;
        case (state_q)
            S_IDLE:  if (turn_start) state_d = S_ORDER;
            S_ORDER: state_d = S_REQ1;
            S_REQ1, S_REQ2: begin
                if (calc.calc_ack) begin
                    hit_ack = 1'b1;
                    state_d = (state_q == S_REQ1) ? S_SHOW1 : S_SHOW2;
                end else if (tmo_q == TMO_LAST) begin
                    hit_tmo = 1'b1;
                    state_d = (state_q == S_REQ1) ? S_SHOW1 : S_SHOW2;
                end
            end
            S_SHOW1: if (text_ack) state_d = S_CHECK;
            S_SHOW2: if (text_ack) state_d = S_DONE;
            S_CHECK: state_d = def_dead ? S_DONE : S_REQ2;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= S_IDLE;
            first_q          <= 1'b0;
            pspd_q           <= '0;
            espd_q           <= '0;
            php_q            <= '0;
            ehp_q            <= '0;
            tmo_q            <= '0;
            calc_req_q       <= 1'b0;
            calc_is_player_q <= 1'b0;
            pfaint_q         <= 1'b0;
            efaint_q         <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            first_q          <= first_d;
            calc_req_q       <= (state_d == S_REQ1) || (state_d == S_REQ2);
            calc_is_player_q <= (state_d == S_REQ2) ? ~first_d : first_d;
            // Counter restarts on every entry to a request state.
            if ((state_q == S_REQ1 || state_q == S_REQ2) && state_d == state_q)
                tmo_q <= tmo_q + 1'b1;
            else
                tmo_q <= '0;
            if (state_q == S_IDLE && turn_start) begin
                pspd_q   <= player_speed;
                espd_q   <= enemy_speed;
                php_q    <= player_hp_in;
                ehp_q    <= enemy_hp_in;
                err_q    <= 1'b0;
                pfaint_q <= 1'b0;
                efaint_q <= 1'b0;
            end
            if (hit_ack) begin
                if (atk_player) ehp_q <= sat_sub(ehp_q, calc.calc_damage);
                else            php_q <= sat_sub(php_q, calc.calc_damage);
            end
            if (hit_tmo) err_q <= 1'b1;
            if (state_d == S_DONE && state_q != S_DONE) begin
                pfaint_q <= (php_q == '0);
                efaint_q <= (ehp_q == '0);
            end
        end
    end

    assign calc.calc_req       = calc_req_q;
    assign calc.calc_is_player = calc_is_player_q;
    assign show_attack         = (state_q == S_SHOW1) || (state_q == S_SHOW2);
    assign show_is_player      = atk_player;
    assign player_hp           = php_q;
    assign enemy_hp            = ehp_q;
    assign turn_done           = (state_q == S_DONE);
    assign player_fainted      = pfaint_q;
    assign enemy_fainted       = efaint_q;
    assign calc_err            = err_q;
    assign busy                = (state_q != S_IDLE);
endmodule
